fifo_port_scheduler: RTL and testbench
======================================

FIFO_PORT_SCHEDULER -- requirements
Module: fifo_port_scheduler

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of every data bus.
REQ-002 SHALL have parameter CNT_W, default 16, width of each per-source accept counter.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 SHALL have port i_mode  input  1  write arbitration: 0 = round-robin, 1 = fixed priority to source 0.
REQ-006 SHALL have ports i_s0_valid, i_s1_valid  input  1  write request from source 0/1.
REQ-007 SHALL have ports i_s0_data, i_s1_data  input  DATA_W  write data from source 0/1.
REQ-008 SHALL have ports o_s0_ready, o_s1_ready  output  1  accept strobe to source 0/1.
REQ-009 SHALL have port o_wren  output  1  FIFO write enable.
REQ-010 SHALL have port o_wrdata  output  DATA_W  FIFO write data.
REQ-011 SHALL have port i_full  input  1  FIFO full flag.
REQ-012 SHALL have port i_empty  input  1  FIFO empty flag.
REQ-013 SHALL have port o_rden  output  1  FIFO read enable.
REQ-014 SHALL have port i_rddata  input  DATA_W  FIFO read data, valid the cycle after o_rden.
REQ-015 SHALL have ports o_m_valid (output, 1), o_m_data (output, DATA_W), i_m_ready (input, 1)  consumer stream.
REQ-016 SHALL have ports o_s0_cnt, o_s1_cnt  output  CNT_W  accepted-write counts per source.

Function
REQ-017 Write handshake SHALL be combinational: sX accepted in a cycle iff i_sX_valid=1, o_sX_ready=1; at most one source accepted per cycle.
REQ-018 o_sX_ready SHALL be 0 for both sources whenever i_full=1.
REQ-019 With i_full=0 and one source valid, that source SHALL receive ready regardless of mode or pointer.
REQ-020 With i_full=0, both valid, i_mode=1: source 0 SHALL win.
REQ-021 With i_full=0, both valid, i_mode=0: source named by 1-bit pointer rr_ptr SHALL win.
REQ-022 rr_ptr SHALL move to the non-winning source only on an accepted write; unchanged otherwise, including in mode 1.
REQ-023 o_wren SHALL equal (accept of s0 OR accept of s1) in the same cycle; o_wrdata SHALL be the winner's data, 0 when o_wren=0.
REQ-024 o_sX_cnt SHALL increment by 1 per accepted write from sX and saturate at all-ones (no wrap).
REQ-025 Read side SHALL hold a 2-entry output buffer (occ 0..2) plus a 1-bit in-flight flag (read issued last cycle).
REQ-026 o_rden SHALL be 1 iff i_empty=0 and (occ + inflight - pop) < 2, where pop = o_m_valid AND i_m_ready in that cycle.
REQ-027 In the cycle after o_rden=1, i_rddata SHALL be written into the buffer tail at the rising edge.
REQ-028 o_m_valid SHALL be 1 iff occ > 0; o_m_data SHALL be the buffer head, registered, held stable while o_m_valid=1 and i_m_ready=0.
REQ-029 Simultaneous capture and pop SHALL leave occ unchanged and preserve order.
REQ-030 Minimum latency: FIFO non-empty at cycle N -> o_rden at N -> o_m_valid at N+2.
REQ-031 With i_m_ready held 1 and FIFO non-empty, SHALL sustain one word per cycle.
REQ-032 Buffer SHALL never overflow; data order SHALL equal FIFO order.

Reset
REQ-033 While reset=0 at a rising edge: occ=0, inflight=0, rr_ptr=0, counters=0, o_m_valid=0, o_m_data=0.
REQ-034 During reset=0, o_rden, o_wren, o_s0_ready, o_s1_ready SHALL be forced 0.
REQ-035 Reset mid-operation SHALL discard buffered and in-flight data; the first cycle after release SHALL behave as idle.

Verification
REQ-036 Mode 0, both sources valid 6 cycles, i_full=0 -> grants s0,s1,s0,s1,s0,s1; both counters = 3.
REQ-037 Mode 1, both valid 4 cycles -> s0 granted 4 times, o_s1_ready=0, o_s1_cnt=0.
REQ-038 i_full=1 with both valid -> o_wren=0, both readies 0, rr_ptr and counters unchanged.
REQ-039 FIFO holds 0x11,0x22,0x33, i_m_ready=1 -> o_rden at cycles 0,1,2; o_m_data 0x11,0x22,0x33 at cycles 2,3,4.
REQ-040 i_m_ready=0, FIFO holds 5 words -> exactly 2 reads issued, occ=2, o_m_data=first word stable; release ready -> remaining 3 delivered in order.
REQ-041 Force o_s0_cnt to all-ones via accepts -> stays all-ones; reset low one cycle mid-stream -> all outputs 0, o_m_valid=0.

Source files
------------

// File: rtl/fifo_port_scheduler.sv
// Two-source write arbiter feeding an external FIFO, plus a read side that
// prefetches FIFO words into a 2-entry registered output buffer.
module fifo_port_scheduler #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_mode,
    input  logic              i_s0_valid,
    input  logic              i_s1_valid,
    input  logic [DATA_W-1:0] i_s0_data,
    input  logic [DATA_W-1:0] i_s1_data,
    output logic              o_s0_ready,
    output logic              o_s1_ready,
    output logic              o_wren,
    output logic [DATA_W-1:0] o_wrdata,
    input  logic              i_full,
    input  logic              i_empty,
    output logic              o_rden,
    input  logic [DATA_W-1:0] i_rddata,
    output logic              o_m_valid,
    output logic [DATA_W-1:0] o_m_data,
    input  logic              i_m_ready,
    output logic [CNT_W-1:0]  o_s0_cnt,
    output logic [CNT_W-1:0]  o_s1_cnt
);

    logic              rr_ptr;
    logic [1:0]        occ;
    logic              inflight;
    logic [DATA_W-1:0] buf_head;
    logic [DATA_W-1:0] buf_tail;
    logic [CNT_W-1:0]  cnt0;
    logic [CNT_W-1:0]  cnt1;

    logic              s0_wins;
    logic              grant0;
    logic              grant1;
    logic              pop;
    logic [2:0]        level;
    logic [1:0]        tail_idx;

    always_comb begin
        s0_wins  = i_s0_valid && (!i_s1_valid || i_mode || !rr_ptr);
        grant0   = reset && !i_full && s0_wins;
        grant1   = reset && !i_full && i_s1_valid && !s0_wins;
        pop      = (occ != 2'd0) && i_m_ready;
        // buffer occupancy once this cycle's pop and the in-flight capture settle
        level    = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
        tail_idx = occ - {1'b0, pop};
    end

    assign o_s0_ready = grant0;
    assign o_s1_ready = grant1;
    assign o_wren     = grant0 | grant1;
    assign o_wrdata   = grant0 ? i_s0_data : (grant1 ? i_s1_data : '0);
    assign o_rden     = reset && !i_empty && (level < 3'd2);
    assign o_m_valid  = (occ != 2'd0);
    assign o_m_data   = buf_head;
    assign o_s0_cnt   = cnt0;
    assign o_s1_cnt   = cnt1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr   <= 1'b0;
            occ      <= 2'd0;
            inflight <= 1'b0;
            buf_head <= '0;
            buf_tail <= '0;
            cnt0     <= '0;
            cnt1     <= '0;
        end else begin
            // pointer names the loser so it wins the next contended cycle
            if (o_wren)
                rr_ptr <= grant0;
            if (grant0 && (cnt0 != '1))
                cnt0 <= cnt0 + CNT_W'(1);
            if (grant1 && (cnt1 != '1))
                cnt1 <= cnt1 + CNT_W'(1);
            if (pop)
                buf_head <= buf_tail;
            if (inflight) begin
                if (tail_idx == 2'd0)
                    buf_head <= i_rddata;
                else
                    buf_tail <= i_rddata;
            end
            occ      <= occ + {1'b0, inflight} - {1'b0, pop};
            inflight <= o_rden;
        end
    end

endmodule

// File: tb/tb_fifo_port_scheduler.sv
// Bench for fifo_port_scheduler: the bench plays the external FIFO and
// compares every cycle against a queue-based model, plus literal scenarios.
module tb_fifo_port_scheduler;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;
    localparam int DEPTH  = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              mode;
    logic              s0v, s1v;
    logic [DATA_W-1:0] s0d, s1d;
    logic              s0_ready, s1_ready;
    logic              wren;
    logic [DATA_W-1:0] wrdata;
    logic              i_full, i_empty;
    logic              rden;
    logic [DATA_W-1:0] i_rddata;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ready;
    logic [CNT_W-1:0]  s0_cnt, s1_cnt;
    logic              force_full;

    always #5 clk = ~clk;

    fifo_port_scheduler #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(rst), .i_mode(mode),
        .i_s0_valid(s0v), .i_s1_valid(s1v), .i_s0_data(s0d), .i_s1_data(s1d),
        .o_s0_ready(s0_ready), .o_s1_ready(s1_ready),
        .o_wren(wren), .o_wrdata(wrdata), .i_full(i_full), .i_empty(i_empty),
        .o_rden(rden), .i_rddata(i_rddata),
        .o_m_valid(m_valid), .o_m_data(m_data), .i_m_ready(m_ready),
        .o_s0_cnt(s0_cnt), .o_s1_cnt(s1_cnt)
    );

    int checks = 0;
    int errors = 0;

    // reference model state
    bit [7:0] fifo_q[$];
    bit [7:0] exp_out[$];
    bit [7:0] got[$];
    int       outstanding = 0;
    bit       m_inflight = 0;
    bit       m_ptr = 0;
    int       cnt0_m = 0, cnt1_m = 0;
    bit       known = 0, after_rst = 0;
    bit [7:0] rd_word = 0;
    bit [7:0] g_hist = 0;
    int       tc = 16;
    bit       obs_rden[16];
    bit       obs_mv[16];
    bit [7:0] obs_md[16];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        bit       vexp, popm, rexp, has_win, win;
        bit [7:0] wd;
        i_full  = force_full || (fifo_q.size() >= DEPTH);
        i_empty = (fifo_q.size() == 0);
        #2;
        vexp = 0;
        rexp = 0;
        if (known) begin
            vexp = (outstanding - int'(m_inflight)) > 0;
            chk("m_valid", m_valid, vexp);
            if (vexp) chk("m_data", m_data, exp_out[0]);
            if (after_rst) chk("m_data_after_reset", m_data, 0);
            chk("s0_cnt", s0_cnt, cnt0_m);
            chk("s1_cnt", s1_cnt, cnt1_m);
        end
        if (tc < 16) begin
            obs_rden[tc] = rden;
            obs_mv[tc]   = m_valid;
            obs_md[tc]   = m_data;
            tc++;
        end
        if (wren) g_hist = {g_hist[6:0], s1_ready};
        if (rst && m_valid && m_ready) got.push_back(m_data);

        if (!rst) begin
            chk("s0_ready_rst", s0_ready, 0);
            chk("s1_ready_rst", s1_ready, 0);
            chk("wren_rst", wren, 0);
            chk("rden_rst", rden, 0);
            outstanding = 0;
            m_inflight  = 0;
            exp_out.delete();
            m_ptr  = 0;
            cnt0_m = 0;
            cnt1_m = 0;
            known     = 1;
            after_rst = 1;
        end else begin
            after_rst = 0;
            has_win = 0;
            win     = 0;
            if (!i_full) begin
                if (s0v && s1v) begin
                    has_win = 1;
                    win = mode ? 1'b0 : m_ptr;
                end else if (s0v || s1v) begin
                    has_win = 1;
                    win = s1v;
                end
            end
            wd = !has_win ? 8'h00 : (win ? s1d : s0d);
            chk("s0_ready", s0_ready, has_win && !win);
            chk("s1_ready", s1_ready, has_win && win);
            chk("wren", wren, has_win);
            chk("wrdata", wrdata, wd);

            popm = vexp && m_ready;
            rexp = !i_empty && ((outstanding - int'(popm)) < 2);
            chk("rden", rden, rexp);

            if (popm) begin
                void'(exp_out.pop_front());
                outstanding--;
            end
            if (rexp) begin
                rd_word = fifo_q.pop_front();
                exp_out.push_back(rd_word);
                outstanding++;
            end
            m_inflight = rexp;
            if (has_win) begin
                fifo_q.push_back(wd);
                m_ptr = !win;
                if (!win && cnt0_m < CMAX) cnt0_m++;
                if (win && cnt1_m < CMAX) cnt1_m++;
            end
        end
        @(posedge clk);
        #1;
        i_rddata = m_inflight ? rd_word : DATA_W'($urandom);
    endtask

    task automatic do_reset();
        rst = 0;
        step();
        rst = 1;
    endtask

    task automatic idle_inputs();
        s0v = 0; s1v = 0; s0d = 0; s1d = 0;
        m_ready = 1; force_full = 0; mode = 0;
    endtask

    initial begin
        rst = 0;
        i_rddata = 0;
        idle_inputs();
        do_reset();

        // round-robin alternation with both sources contending
        g_hist = 0;
        s0v = 1; s1v = 1;
        for (int i = 0; i < 6; i++) begin
            s0d = 8'h10 + 8'(i); s1d = 8'h20 + 8'(i);
            step();
        end
        chk("rr_grant_seq", {2'b00, g_hist[5:0]}, 8'b0001_0101);
        chk("rr_cnt0", s0_cnt, 3);
        chk("rr_cnt1", s1_cnt, 3);

        // single s0 accept leaves the pointer on s1
        s1v = 0;
        step();
        // full blocks everything and freezes pointer/counters
        s1v = 1; force_full = 1;
        for (int i = 0; i < 3; i++) step();
        chk("full_cnt0", s0_cnt, 4);
        chk("full_cnt1", s1_cnt, 3);
        force_full = 0;
        step();
        chk("ptr_kept_s1_wins", g_hist[0], 1);

        // fixed priority
        idle_inputs();
        do_reset();
        mode = 1; s0v = 1; s1v = 1;
        for (int i = 0; i < 4; i++) step();
        chk("prio_cnt0", s0_cnt, 4);
        chk("prio_cnt1", s1_cnt, 0);

        // minimum latency and streaming
        idle_inputs();
        do_reset();
        fifo_q = '{8'h11, 8'h22, 8'h33};
        tc = 0;
        for (int i = 0; i < 6; i++) step();
        chk("lat_rden", {obs_rden[0], obs_rden[1], obs_rden[2], obs_rden[3], obs_rden[4], obs_rden[5]}, 6'b111000);
        chk("lat_mvalid", {obs_mv[0], obs_mv[1], obs_mv[2], obs_mv[3], obs_mv[4], obs_mv[5]}, 6'b001110);
        chk("lat_d2", obs_md[2], 8'h11);
        chk("lat_d3", obs_md[3], 8'h22);
        chk("lat_d4", obs_md[4], 8'h33);

        // backpressure: buffer fills to two and holds the head
        idle_inputs();
        do_reset();
        fifo_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        m_ready = 0;
        tc = 0;
        for (int i = 0; i < 6; i++) step();
        chk("bp_reads", int'(obs_rden[0]) + int'(obs_rden[1]) + int'(obs_rden[2]) +
                        int'(obs_rden[3]) + int'(obs_rden[4]) + int'(obs_rden[5]), 2);
        chk("bp_hold_d3", obs_md[3], 8'hA1);
        chk("bp_hold_d5", obs_md[5], 8'hA1);
        chk("bp_fifo_left", fifo_q.size(), 3);
        got.delete();
        m_ready = 1;
        for (int i = 0; i < 10; i++) step();
        chk("bp_count", got.size(), 5);
        for (int i = 0; i < 5 && i < got.size(); i++)
            chk("bp_order", got[i], 8'hA1 + 8'(i));

        // counter saturation then reset mid-stream
        idle_inputs();
        do_reset();
        s0v = 1;
        for (int i = 0; i < 22; i++) begin
            s0d = DATA_W'($urandom);
            step();
        end
        chk("sat_cnt0", s0_cnt, CMAX);
        rst = 0;
        step();
        chk("rst_mvalid", m_valid, 0);
        chk("rst_mdata", m_data, 0);
        chk("rst_cnt0", s0_cnt, 0);
        chk("rst_wren", wren, 0);
        rst = 1;
        s0v = 0;
        step();

        // randomized phases, one per arbitration mode
        for (int ph = 0; ph < 2; ph++) begin
            idle_inputs();
            do_reset();
            mode = ph[0];
            for (int i = 0; i < 600; i++) begin
                rst        = ($urandom_range(99) != 0);
                s0v        = $urandom_range(1);
                s1v        = $urandom_range(1);
                s0d        = DATA_W'($urandom);
                s1d        = DATA_W'($urandom);
                m_ready    = ($urandom_range(3) != 0);
                force_full = ($urandom_range(7) == 0);
                step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
